bin2bcd_seq: RTL
================

// Module: bin2bcd_seq
//
// PURPOSE
//  Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method.
//  Sits directly upstream of the 4-digit seven-segment display driver.
//  Takes the binary sum/product result and produces the packed 16-bit BCD word.
//  That word feeds the display's bcd input and stays stable between conversions.
//
// PARAMETERS
//  BIN_W       16    width of the binary input operand
//  DIGITS      4     BCD digits presented on the output (4 bits each)
//  SCR_DIGITS  5     internal scratch digits; must satisfy 10^SCR_DIGITS > 2^BIN_W-1
//  OVF_CODE    4'hE  nibble placed in every output digit when the value exceeds 10^DIGITS-1
//
// PORTS
//  clk_25mhz  in   1           system clock, 25 MHz, all logic on posedge
//  rst        in   1           synchronous, active-high reset
//  start      in   1           request conversion of bin; sampled only in IDLE
//  bin        in   BIN_W       binary operand; captured on the accepting edge, free afterwards
//  busy       out  1           high while a conversion is in flight (SHIFT/FINISH states)
//  done       out  1           one-cycle pulse: bcd/ovf updated this cycle
//  bcd        out  4*DIGITS    packed BCD result, digit 0 in [3:0]; held until the next done
//  ovf        out  1           high if the last result exceeded 10^DIGITS-1; held with bcd
//
// BEHAVIOUR
//  Reset (rst=1 at a posedge)
//   - state=IDLE; busy=0; done=0; bcd=0; ovf=0; scratch and counter cleared.
//   - Reset mid-conversion aborts the conversion; no done pulse is produced.
//  FSM states: IDLE, SHIFT, FINISH.
//   - IDLE: on an edge with start=1, load shift reg = {SCR_DIGITS*4 zeros, bin}.
//     Set cnt=BIN_W, busy=1, go to SHIFT. With start=0, stay.
//   - SHIFT: each edge, every scratch digit >=5 gets +3 (all digits in parallel, combinational).
//     The whole {scratch,bin} register is then shifted left 1 and cnt decrements.
//     When cnt reaches 1 on an edge, that edge performs the final shift and goes to FINISH.
//     Exactly BIN_W shifts are performed.
//   - FINISH: ovf_n = any scratch digit above index DIGITS-1 is nonzero.
//     bcd <= ovf_n ? {DIGITS{OVF_CODE}} : scratch[4*DIGITS-1:0]; ovf <= ovf_n.
//     Also done<=1, busy<=0, go to IDLE.
//  Timing: start sampled at edge N -> shifts at edges N+1..N+BIN_W.
//   - bcd/ovf/done update at edge N+BIN_W+1 (17 cycles at defaults).
//   - done is high for exactly one cycle, which is an IDLE cycle.
//   - A start in the done cycle is accepted, so back-to-back throughput is one conversion per BIN_W+2 cycles.
//  start while busy=1 is ignored entirely; bin changes while busy have no effect.
//  bcd/ovf never glitch mid-conversion; the display may read them every cycle.
//  Boundaries:
//   - bin=0 gives bcd 0000.
//   - bin=10^DIGITS-1 (9999) gives no overflow.
//   - bin=10^DIGITS (10000) up to 2^BIN_W-1 gives overflow.
//  Arithmetic: each add-3 is on a 4-bit digit; an input >=5 never exceeds 4'hC, so there is no carry out.
//
// STRUCTURE
//  Shared package/header: state encodings (IDLE/SHIFT/FINISH, 2 bits) and OVF_CODE default.
//  Sub-module bcd_digit_adj: 4-bit combinational "if >=4'd5 then +3"; instantiated SCR_DIGITS times via generate.
//  Top holds the FSM, counter ($clog2(BIN_W+1) bits), {scratch,bin} shift register and output registers.
//
// TESTING
//  1. Assert rst 3 cycles -> bcd=16'h0000, ovf=0, busy=0, done=0.
//  2. bin=16'd1234, start 1 cycle -> busy next cycle; after 17 cycles done=1 for exactly 1 cycle, bcd=16'h1234, ovf=0.
//  3. Boundaries: bin=0 -> 16'h0000; bin=9999 -> 16'h9999, ovf=0; bin=10000 -> 16'hEEEE, ovf=1; bin=65535 -> 16'hEEEE, ovf=1.
//  4. Start 4321 and hold start high; change bin to 5 mid-conversion.
//     -> Result is 16'h4321 and the second conversion begins in the done cycle.
//     -> Its done arrives 18 cycles after the first done.
//  5. rst pulsed at shift 8 of a 1234 conversion -> no done, bcd=0; a fresh start of 42 then yields 16'h0042.
//  6. Random bin in 0..9999, 1000 iterations -> bcd equals the reference decimal digits; bcd stable between done pulses.

Source files
------------

// File: rtl/bin2bcd_seq_pkg.sv
// rtl/bin2bcd_seq_pkg.sv - shared state encoding and defaults for the binary-to-BCD converter
// Purpose: FSM state type and the default overflow display code.
// Ports: none (package).
package bin2bcd_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // Nibble shown in every display digit when the value does not fit.
  localparam logic [3:0] OVF_CODE_DEF = 4'hE;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// rtl/bin2bcd_seq_if.sv - request/result bundle between the requester and the converter
// Purpose: groups start/bin request and busy/done/bcd/ovf result signals.
// Ports (master = requester side, slave = converter side):
//   start, bin            requester -> converter
//   busy, done, bcd, ovf  converter -> requester
interface bin2bcd_seq_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 4
);

  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  ovf;

  modport master (
    output start, bin,
    input  busy, done, bcd, ovf
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, ovf
  );

endinterface

// File: rtl/bin2bcd_seq_bcd_digit_adj.sv
// rtl/bin2bcd_seq_bcd_digit_adj.sv - one double-dabble digit correction
// Purpose: adds 3 to a BCD digit that is 5 or more, so the following shift carries correctly.
// Ports:
//   din   in   4  scratch digit before the shift
//   dout  out  4  corrected digit
module bcd_digit_adj (
  input  logic [3:0] din,
  input  logic       unused_tie, // kept low; lets every instance share one port shape
  output logic [3:0] dout
);

  logic unused_ok;
  assign unused_ok = unused_tie;

  // A digit >= 5 maxes out at 4'hC after +3, so no carry leaves the nibble.
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary-to-BCD converter
// Purpose: converts bin to packed BCD over BIN_W shift cycles; result held until the next done.
// Ports:
//   clk_25mhz  in   system clock, posedge
//   rst        in   synchronous active-high reset
//   bus        slave side of bin2bcd_seq_if (start, bin in; busy, done, bcd, ovf out)
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int         BIN_W      = 16,
  parameter int         DIGITS     = 4,
  parameter int         SCR_DIGITS = 5,
  parameter logic [3:0] OVF_CODE   = OVF_CODE_DEF
) (
  input  logic        clk_25mhz,
  input  logic        rst,
  bin2bcd_seq_if.slave bus
);

  localparam int SW = 4 * SCR_DIGITS;
  localparam int OW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);

  state_t              state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [SW+BIN_W-1:0] sr, sr_n;     // {scratch digits, remaining binary bits}
  logic [SW-1:0]       adj;
  logic [OW-1:0]       bcd_q, bcd_n;
  logic                ovf_q, ovf_n;
  logic                done_q, done_n;
  logic                hi_nz;

  // All scratch digits are corrected in parallel ahead of each shift.
  for (genvar g = 0; g < SCR_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din        (sr[BIN_W + 4*g +: 4]),
      .unused_tie (1'b0),
      .dout       (adj[4*g +: 4])
    );
  end

  // Any nonzero digit beyond the displayed ones means the value does not fit.
  assign hi_nz = |sr[SW+BIN_W-1 : BIN_W+OW];

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sr_n    = sr;
    bcd_n   = bcd_q;
    ovf_n   = ovf_q;
    done_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          sr_n    = {{SW{1'b0}}, bus.bin};
          cnt_n   = CW'(BIN_W);
          state_n = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sr_n  = {adj, sr[BIN_W-1:0]} << 1;
        cnt_n = cnt - 1'b1;
        if (cnt == CW'(1)) begin
          state_n = ST_FINISH;
        end
      end
      ST_FINISH: begin
        ovf_n   = hi_nz;
        bcd_n   = hi_nz ? {DIGITS{OVF_CODE}} : sr[BIN_W +: OW];
        done_n  = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      sr     <= '0;
      bcd_q  <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      sr     <= sr_n;
      bcd_q  <= bcd_n;
      ovf_q  <= ovf_n;
      done_q <= done_n;
    end
  end

  assign bus.busy = (state != ST_IDLE);
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
  assign bus.ovf  = ovf_q;

endmodule
